// File: rtl/datapath_sequencer_if.sv
// Handshake and control bundle between the datapath sequencer and the CPU datapath.
// The sequencer uses the master modport and the datapath uses the slave modport.
interface datapath_sequencer_if;
    logic        start;
    logic [15:0] instr;
    logic        cond_true;
    logic        mem_ready;
    logic        IR_load;
    logic        PC_en;
    logic [1:0]  PC_sel;
    logic        mem_req;
    logic        mem_we;
    logic        addr_sel;
    logic        RF_we;
    logic        wb_sel;
    logic        alu_imm;
    logic        illegal;
    logic        halted;
    logic        mem_err;

    modport master (
        input  start, instr, cond_true, mem_ready,
        output IR_load, PC_en, PC_sel, mem_req, mem_we, addr_sel,
               RF_we, wb_sel, alu_imm, illegal, halted, mem_err
    );

    modport slave (
        output start, instr, cond_true, mem_ready,
        input  IR_load, PC_en, PC_sel, mem_req, mem_we, addr_sel,
               RF_we, wb_sel, alu_imm, illegal, halted, mem_err
    );
endinterface

// File: rtl/datapath_sequencer.sv
// Multi-cycle fetch/decode/execute/mem/writeback/pc-update control sequencer.
// Optional memory-wait watchdog enabled by defining SEQ_TIMEOUT_EN.
module datapath_sequencer #(
    parameter int TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    datapath_sequencer_if.master   bus
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_FETCH     = 3'd1;
    localparam logic [2:0] S_DECODE    = 3'd2;
    localparam logic [2:0] S_EXECUTE   = 3'd3;
    localparam logic [2:0] S_MEM       = 3'd4;
    localparam logic [2:0] S_WRITEBACK = 3'd5;
    localparam logic [2:0] S_PCUPDATE  = 3'd6;
    localparam logic [2:0] S_HALT      = 3'd7;

    localparam logic [2:0] C_ALU_REG = 3'd0;
    localparam logic [2:0] C_ALU_IMM = 3'd1;
    localparam logic [2:0] C_LOAD    = 3'd2;
    localparam logic [2:0] C_STORE   = 3'd3;
    localparam logic [2:0] C_BRANCH  = 3'd4;
    localparam logic [2:0] C_NOP     = 3'd5;
    localparam logic [2:0] C_HALT    = 3'd6;

    // Illegal encodings map to C_NOP; they still retire through PCUPDATE.
    function automatic logic [2:0] classify(input logic [3:0] op, input logic [3:0] ext);
        logic [2:0] cls;
        case (op)
            4'h0:                         cls = C_ALU_REG;
            4'h1, 4'h2, 4'h3, 4'h5, 4'h6,
            4'h7, 4'h9, 4'hB, 4'hD:       cls = C_ALU_IMM;
            4'h4: begin
                if (ext == 4'h0) begin
                    cls = C_LOAD;
                end else if (ext == 4'h4) begin
                    cls = C_STORE;
                end else begin
                    cls = C_NOP;
                end
            end
            4'hC:                         cls = C_BRANCH;
            4'hF:                         cls = C_HALT;
            default:                      cls = C_NOP;
        endcase
        return cls;
    endfunction

    logic [2:0] state_r;
    logic [2:0] state_nxt_s;
    logic [2:0] cls_r;
    logic [2:0] dec_cls_s;
    logic       waiting_s;
    logic       timeout_hit_s;
    logic       mem_err_s;

    logic       ir_load_s;
    logic       pc_en_s;
    logic [1:0] pc_sel_s;
    logic       mem_req_s;
    logic       mem_we_s;
    logic       addr_sel_s;
    logic       rf_we_s;
    logic       wb_sel_s;
    logic       alu_imm_s;
    logic       illegal_s;
    logic       halted_s;

    logic       unused_instr_s;
    assign unused_instr_s = ^{bus.instr[11:8], bus.instr[3:0]};

    assign dec_cls_s = classify(bus.instr[15:12], bus.instr[7:4]);
    assign waiting_s = ((state_r == S_FETCH) || (state_r == S_MEM)) && !bus.mem_ready;

`ifdef SEQ_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] wait_cnt_r;
    logic          mem_err_r;

    assign timeout_hit_s = waiting_s && (wait_cnt_r == CW'(TIMEOUT - 1));
    assign mem_err_s     = mem_err_r;

    // Consecutive-wait counter; a timeout forces a state change, which clears it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt_r <= '0;
        end else if (waiting_s && !timeout_hit_s) begin
            wait_cnt_r <= wait_cnt_r + CW'(1);
        end else begin
            wait_cnt_r <= '0;
        end
    end

    // Sticky watchdog fault flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_err_r <= 1'b0;
        end else if (timeout_hit_s) begin
            mem_err_r <= 1'b1;
        end else begin
            mem_err_r <= mem_err_r;
        end
    end
`else
    logic unused_timeout_s;
    assign unused_timeout_s = (TIMEOUT > 0);
    assign timeout_hit_s    = 1'b0;
    assign mem_err_s        = 1'b0;
`endif

    // State register and instruction class latched during DECODE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= S_IDLE;
            cls_r   <= C_NOP;
        end else begin
            state_r <= state_nxt_s;
            if (state_r == S_DECODE) begin
                cls_r <= dec_cls_s;
            end
        end
    end

    // Next-state selection.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (bus.start) begin
                    state_nxt_s = S_FETCH;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_FETCH: begin
                if (timeout_hit_s) begin
                    state_nxt_s = S_HALT;
                end else if (bus.mem_ready) begin
                    state_nxt_s = S_DECODE;
                end else begin
                    state_nxt_s = S_FETCH;
                end
            end
            S_DECODE: begin
                case (dec_cls_s)
                    C_ALU_REG, C_ALU_IMM,
                    C_LOAD, C_STORE:      state_nxt_s = S_EXECUTE;
                    C_HALT:               state_nxt_s = S_HALT;
                    default:              state_nxt_s = S_PCUPDATE;
                endcase
            end
            S_EXECUTE: begin
                if ((cls_r == C_LOAD) || (cls_r == C_STORE)) begin
                    state_nxt_s = S_MEM;
                end else begin
                    state_nxt_s = S_WRITEBACK;
                end
            end
            S_MEM: begin
                if (timeout_hit_s) begin
                    state_nxt_s = S_HALT;
                end else if (!bus.mem_ready) begin
                    state_nxt_s = S_MEM;
                end else if (cls_r == C_LOAD) begin
                    state_nxt_s = S_WRITEBACK;
                end else begin
                    state_nxt_s = S_PCUPDATE;
                end
            end
            S_WRITEBACK: state_nxt_s = S_PCUPDATE;
            S_PCUPDATE:  state_nxt_s = S_FETCH;
            S_HALT:      state_nxt_s = S_HALT;
            default:     state_nxt_s = S_IDLE;
        endcase
    end

    // Datapath enables decoded from state; IR_load, illegal and PC_sel also use live inputs.
    always_comb begin
        ir_load_s  = 1'b0;
        pc_en_s    = 1'b0;
        pc_sel_s   = 2'b00;
        mem_req_s  = 1'b0;
        mem_we_s   = 1'b0;
        addr_sel_s = 1'b0;
        rf_we_s    = 1'b0;
        wb_sel_s   = 1'b0;
        alu_imm_s  = 1'b0;
        illegal_s  = 1'b0;
        halted_s   = 1'b0;
        case (state_r)
            S_FETCH: begin
                mem_req_s = 1'b1;
                ir_load_s = bus.mem_ready;
            end
            S_DECODE: begin
                alu_imm_s = (dec_cls_s == C_ALU_IMM);
                illegal_s = (dec_cls_s == C_NOP);
            end
            S_EXECUTE: begin
                alu_imm_s = (cls_r == C_ALU_IMM);
            end
            S_MEM: begin
                mem_req_s  = 1'b1;
                addr_sel_s = 1'b1;
                mem_we_s   = (cls_r == C_STORE);
            end
            S_WRITEBACK: begin
                rf_we_s  = 1'b1;
                wb_sel_s = (cls_r == C_LOAD);
            end
            S_PCUPDATE: begin
                pc_en_s = 1'b1;
                if ((cls_r == C_BRANCH) && bus.cond_true) begin
                    pc_sel_s = 2'b01;
                end else begin
                    pc_sel_s = 2'b00;
                end
            end
            S_HALT: begin
                halted_s = 1'b1;
            end
            default: begin
                halted_s = 1'b0;
            end
        endcase
    end

    assign bus.IR_load  = ir_load_s;
    assign bus.PC_en    = pc_en_s;
    assign bus.PC_sel   = pc_sel_s;
    assign bus.mem_req  = mem_req_s;
    assign bus.mem_we   = mem_we_s;
    assign bus.addr_sel = addr_sel_s;
    assign bus.RF_we    = rf_we_s;
    assign bus.wb_sel   = wb_sel_s;
    assign bus.alu_imm  = alu_imm_s;
    assign bus.illegal  = illegal_s;
    assign bus.halted   = halted_s;
    assign bus.mem_err  = mem_err_s;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Self-checking bench: a phase-level model expands each instruction into the
// expected per-cycle control outputs and the memory handshake inputs to drive.
module tb_datapath_sequencer;

    localparam int B_IR  = 12;
    localparam int B_PCE = 11;
    localparam int B_PCS = 9;
    localparam int B_REQ = 8;
    localparam int B_WE  = 7;
    localparam int B_AS  = 6;
    localparam int B_RF  = 5;
    localparam int B_WB  = 4;
    localparam int B_IMM = 3;
    localparam int B_ILL = 2;
    localparam int B_HLT = 1;
    localparam int B_ERR = 0;

    typedef struct {
        logic        start;
        logic [15:0] instr;
        logic        cond;
        logic        mr;
        logic [12:0] exp;
    } cyc_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    datapath_sequencer_if bus();

    datapath_sequencer #(.TIMEOUT(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    cyc_t trace[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    logic halted_model;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [12:0] observed();
        return {bus.IR_load, bus.PC_en, bus.PC_sel, bus.mem_req, bus.mem_we, bus.addr_sel,
                bus.RF_we, bus.wb_sel, bus.alu_imm, bus.illegal, bus.halted, bus.mem_err};
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [15:0] rword();
        return 16'($urandom_range(0, 65535));
    endfunction

    task automatic push(input logic st, input logic [15:0] ins, input logic c,
                        input logic mr, input logic [12:0] e);
        cyc_t x;
        x.start = st; x.instr = ins; x.cond = c; x.mr = mr; x.exp = e;
        trace.push_back(x);
    endtask

    // Expand one instruction into its phase sequence from the opcode rules.
    task automatic build_instr(input logic [15:0] ins, input int wf, input int wm, input int cm);
        logic [3:0]  op;
        logic [3:0]  ext;
        logic        is_reg, is_imm, is_ld, is_st, is_br, is_hlt, is_ill, c;
        logic [12:0] e;
        op     = ins[15:12];
        ext    = ins[7:4];
        is_reg = (op == 4'h0);
        is_imm = (op inside {4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'h7, 4'h9, 4'hB, 4'hD});
        is_ld  = (op == 4'h4) && (ext == 4'h0);
        is_st  = (op == 4'h4) && (ext == 4'h4);
        is_br  = (op == 4'hC);
        is_hlt = (op == 4'hF);
        is_ill = !(is_reg || is_imm || is_ld || is_st || is_br || is_hlt);
        for (int i = 0; i < wf; i++) begin
            e = '0; e[B_REQ] = 1'b1;
            push(rbit(), rword(), rbit(), 1'b0, e);
        end
        e = '0; e[B_REQ] = 1'b1; e[B_IR] = 1'b1;
        push(rbit(), rword(), rbit(), 1'b1, e);
        e = '0; e[B_IMM] = is_imm; e[B_ILL] = is_ill;
        push(rbit(), ins, rbit(), rbit(), e);
        if (is_hlt) begin
            for (int i = 0; i < 3; i++) begin
                e = '0; e[B_HLT] = 1'b1;
                push(rbit(), rword(), rbit(), rbit(), e);
            end
            halted_model = 1'b1;
            return;
        end
        if (is_reg || is_imm || is_ld || is_st) begin
            e = '0; e[B_IMM] = is_imm;
            push(rbit(), rword(), rbit(), rbit(), e);
        end
        if (is_ld || is_st) begin
            e = '0; e[B_REQ] = 1'b1; e[B_AS] = 1'b1; e[B_WE] = is_st;
            for (int i = 0; i < wm; i++) push(rbit(), rword(), rbit(), 1'b0, e);
            push(rbit(), rword(), rbit(), 1'b1, e);
        end
        if (is_reg || is_imm || is_ld) begin
            e = '0; e[B_RF] = 1'b1; e[B_WB] = is_ld;
            push(rbit(), rword(), rbit(), rbit(), e);
        end
        c = (cm == 2) ? rbit() : 1'(cm);
        e = '0; e[B_PCE] = 1'b1;
        e[B_PCS+:2] = (is_br && c) ? 2'b01 : 2'b00;
        push(rbit(), rword(), c, rbit(), e);
    endtask

    task automatic start_prog();
        push(1'b0, rword(), rbit(), rbit(), 13'd0);
        push(1'b1, rword(), rbit(), rbit(), 13'd0);
        halted_model = 1'b0;
    endtask

    task automatic run_trace(input string tag, input int limit);
        for (int i = 0; i < trace.size() && (limit < 0 || i < limit); i++) begin
            @(negedge clk);
            bus.start     = trace[i].start;
            bus.instr     = trace[i].instr;
            bus.cond_true = trace[i].cond;
            bus.mem_ready = trace[i].mr;
            #1;
            check($sformatf("%s[%0d]", tag, i), {3'b000, observed()}, {3'b000, trace[i].exp});
        end
        trace.delete();
    endtask

    task automatic reset_dut();
        @(negedge clk);
        bus.start = 1'b0;
        reset     = 1'b0;
        #1;
        check("reset", {3'b000, observed()}, 16'h0000);
        @(negedge clk);
        reset = 1'b1;
    endtask

    function automatic logic [15:0] rand_instr();
        logic [15:0] ins;
        int          r;
        ins = rword();
        r   = $urandom_range(0, 9);
        if (r < 3) begin
            ins[15:12] = 4'h4;
            ins[7:4]   = (r == 0) ? 4'h0 : ((r == 1) ? 4'h4 : ins[7:4]);
        end
        if (ins[15:12] == 4'hF && $urandom_range(0, 3) != 0) ins[15:12] = 4'h0;
        return ins;
    endfunction

    initial begin
        reset         = 1'b0;
        bus.start     = 1'b0;
        bus.instr     = 16'h0000;
        bus.cond_true = 1'b0;
        bus.mem_ready = 1'b0;
        reset_dut();

        // Directed: register ALU, load with 3 MEM waits, store, both branch outcomes.
        start_prog();
        build_instr(16'h0512, 0, 0, 2);
        build_instr(16'h4102, 0, 3, 2);
        build_instr(16'h4142, 1, 2, 2);
        build_instr(16'hC0FE, 0, 0, 1);
        build_instr(16'hC0FE, 2, 0, 0);
        build_instr(16'h8000, 0, 0, 2);
        build_instr(16'h4130, 0, 0, 2);
        build_instr(16'hF000, 0, 0, 2);
        run_trace("dir", -1);
        reset_dut();

        // Randomized programs, each ending early on a HALT.
        for (int p = 0; p < 40; p++) begin
            start_prog();
            for (int k = 0; k < 8 && !halted_model; k++) begin
                build_instr(rand_instr(), $urandom_range(0, 4), $urandom_range(0, 4), 2);
            end
            run_trace($sformatf("rnd%0d", p), -1);
            reset_dut();
        end

        // Async reset while stalled in MEM.
        start_prog();
        build_instr(16'h4102, 0, 6, 2);
        run_trace("stall", 7);
        @(posedge clk);
        #2;
        check("stall_req", {15'd0, bus.mem_req}, 16'h0001);
        reset = 1'b0;
        #1;
        check("rst_async", {3'b000, observed()}, 16'h0000);
        @(negedge clk);
        bus.start = 1'b0;
        reset     = 1'b1;

`ifdef SEQ_TIMEOUT_EN
        begin
            logic [12:0] e;
            start_prog();
            for (int i = 0; i < 16; i++) begin
                e = '0; e[B_REQ] = 1'b1;
                push(rbit(), rword(), rbit(), 1'b0, e);
            end
            for (int i = 0; i < 4; i++) begin
                e = '0; e[B_HLT] = 1'b1; e[B_ERR] = 1'b1;
                push(rbit(), rword(), rbit(), rbit(), e);
            end
            run_trace("tmo", -1);
            reset_dut();
        end
`else
        start_prog();
        build_instr(16'h0512, 20, 0, 2);
        run_trace("longwait", -1);
        reset_dut();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
